// File: rtl/fun_inv_if.sv
// fun_inv_if -- request/result bundle for the fun_inv inverse evaluator.
//
// Handshake: start_i is a request qualified by busy_o. A request is
// accepted on the rising edge where start_i = 1 and busy_o = 0. That
// edge also captures a_bi and y_bi. While busy_o = 1, start_i is ignored
// and never queued. b_bo and err_o are valid from the first cycle busy_o
// is low again, and they hold until the next completion.
//
// Signals:
//   start_i    request (master -> slave)
//   a_bi       operand a, unsigned 8-bit (master -> slave)
//   y_bi       operand y, unsigned 8-bit (master -> slave)
//   busy_o     computation in progress (slave -> master)
//   b_bo       result b, unsigned 8-bit, registered (slave -> master)
//   err_o      result out of range, registered (slave -> master)
//   state_dbg  FSM state, for observation only (slave -> master)
interface fun_inv_if;
    logic       start_i;
    logic [7:0] a_bi;
    logic [7:0] y_bi;
    logic       busy_o;
    logic [7:0] b_bo;
    logic       err_o;
    logic [2:0] state_dbg;

    modport master (
        output start_i, a_bi, y_bi,
        input  busy_o, b_bo, err_o, state_dbg
    );

    modport slave (
        input  start_i, a_bi, y_bi,
        output busy_o, b_bo, err_o, state_dbg
    );
endinterface

// File: rtl/fun_inv.sv
// fun_inv -- inverse of y = sqrt(a + cbrt(b)): computes b = (y*y - a)^3.
//
// The datapath is sequential shift-add:
//   SQ     (8 cycles) sq = y*y, one multiplier bit per cycle, LSB first
//   CHK    (1 cycle)  underflow / overflow test, d = sq - a
//   CUBE_A (3 cycles) p = d*d
//   CUBE_B (3 cycles) c = p*d
//   DONE   (1 cycle)  load b_bo / err_o
// Underflow (sq < a) gives b = 0 with err = 1. d > 6 gives b = 255 with
// err = 1. Otherwise b = d^3 and err = 0.
//
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous reset, active low
//   bus    fun_inv_if.slave (start_i, a_bi, y_bi, busy_o, b_bo, err_o, state_dbg)
//
// Build option:
//   FUN_INV_EARLY_EXIT_EN  when defined, CHK jumps straight to DONE on an
//                          error result (10-cycle latency instead of 16).
//                          Results are identical in both builds.
module fun_inv (
    input  logic      clk_i,
    input  logic      rst_i,
    fun_inv_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SQ     = 3'd1,
        S_CHK    = 3'd2,
        S_CUBE_A = 3'd3,
        S_CUBE_B = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [7:0]  a_r;
    logic [7:0]  y_r;
    logic [15:0] sq_r;
    logic [2:0]  d_r;
    logic [5:0]  p_r;
    logic [7:0]  c_r;
    logic        err_r;
    logic [7:0]  sat_r;
    logic [7:0]  b_r;
    logic        err_out_r;

    // CHK-cycle arithmetic, evaluated from the finished square.
    logic [15:0] diff;
    logic        underflow;
    logic        overflow;
    logic        chk_err;

    assign underflow = (sq_r < {8'h00, a_r});
    assign diff      = sq_r - {8'h00, a_r};
    assign overflow  = !underflow && (diff > 16'd6);
    assign chk_err   = underflow || overflow;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.start_i) state_next = S_SQ;
            S_SQ:     if (cnt == 3'd7) state_next = S_CHK;
`ifdef FUN_INV_EARLY_EXIT_EN
            S_CHK:    state_next = chk_err ? S_DONE : S_CUBE_A;
`else
            S_CHK:    state_next = S_CUBE_A;
`endif
            S_CUBE_A: if (cnt == 3'd2) state_next = S_CUBE_B;
            S_CUBE_B: if (cnt == 3'd2) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy_o    = (state != S_IDLE);
        bus.state_dbg = state;
        bus.b_bo      = b_r;
        bus.err_o     = err_out_r;
    end

    // Datapath
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt       <= 3'd0;
            a_r       <= 8'd0;
            y_r       <= 8'd0;
            sq_r      <= 16'd0;
            d_r       <= 3'd0;
            p_r       <= 6'd0;
            c_r       <= 8'd0;
            err_r     <= 1'b0;
            sat_r     <= 8'd0;
            b_r       <= 8'd0;
            err_out_r <= 1'b0;
        end else begin
            // The step counter restarts at every state change, so each
            // multi-cycle phase sees 0,1,2,... as its bit index.
            if (state == S_IDLE || state_next != state) begin
                cnt <= 3'd0;
            end else begin
                cnt <= cnt + 3'd1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        a_r  <= bus.a_bi;
                        y_r  <= bus.y_bi;
                        sq_r <= 16'd0;
                    end
                end
                S_SQ: begin
                    if (y_r[cnt]) sq_r <= sq_r + ({8'h00, y_r} << cnt);
                end
                S_CHK: begin
                    err_r <= chk_err;
                    sat_r <= underflow ? 8'd0 : 8'd255;
                    // With an error the cube phases run on zero. Only the
                    // saturated value is used in that case.
                    d_r   <= chk_err ? 3'd0 : diff[2:0];
                    p_r   <= 6'd0;
                    c_r   <= 8'd0;
                end
                S_CUBE_A: begin
                    if (d_r[cnt[1:0]]) p_r <= p_r + ({3'b000, d_r} << cnt);
                end
                S_CUBE_B: begin
                    if (d_r[cnt[1:0]]) c_r <= c_r + ({2'b00, p_r} << cnt);
                end
                S_DONE: begin
                    b_r       <= err_r ? sat_r : c_r;
                    err_out_r <= err_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fun_inv.sv
// tb_fun_inv -- bench for fun_inv: table of known vectors, random vectors
// checked against a behavioural model, and hand-written sequences for the
// start handshake and asynchronous reset.
module tb_fun_inv;

`ifdef FUN_INV_EARLY_EXIT_EN
    localparam int ERR_LAT = 10;
`else
    localparam int ERR_LAT = 16;
`endif
    localparam int OK_LAT = 16;

    logic clk;
    logic rst_n;

    fun_inv_if bus();

    fun_inv dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] y;
        logic [7:0] exp_b;
        logic       exp_err;
    } vec_t;

    // Scoreboard: {err, b} and expected busy length, pushed at acceptance.
    logic [8:0] exp_q[$];
    int         lat_q[$];
    logic [7:0] last_b;
    logic       last_err;

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: b = (y*y - a)^3 with saturation.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] y);
        int sq;
        int d;
        sq = int'(y) * int'(y);
        if (sq < int'(a)) return {1'b1, 8'd0};
        d = sq - int'(a);
        if (d > 6) return {1'b1, 8'd255};
        return {1'b0, 8'(d * d * d)};
    endfunction

    // Drive one request; returns #1 after the accepting edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] y, input logic [8:0] exp);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_bi    = a;
        bus.y_bi    = y;
        @(posedge clk);
        exp_q.push_back(exp);
        lat_q.push_back(exp[8] ? ERR_LAT : OK_LAT);
        #1;
        bus.start_i = 1'b0;
    endtask

    // Count busy cycles until completion, then check against the scoreboard.
    // With hammer set, start_i is held high with changing operands for the
    // whole run; on the first idle cycle the operands become a=7, y=3 and
    // start_i stays high.
    task automatic wait_done(input bit hammer);
        int hi;
        logic [8:0] exp;
        int lat;
        hi = 0;
        forever begin
            @(negedge clk);
            if (hi == 0) begin
                check("hold_b", {24'd0, bus.b_bo}, {24'd0, last_b});
                check("hold_err", {31'd0, bus.err_o}, {31'd0, last_err});
            end
            if (!bus.busy_o) break;
            hi++;
            if (hammer) begin
                bus.start_i = 1'b1;
                bus.a_bi    = 8'($urandom_range(0, 255));
                bus.y_bi    = 8'($urandom_range(0, 255));
            end
            if (hi > 40) begin
                check("busy_timeout", 32'(hi), 32'd40);
                break;
            end
        end
        if (hammer) begin
            bus.start_i = 1'b1;
            bus.a_bi    = 8'd7;
            bus.y_bi    = 8'd3;
        end
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            lat = lat_q.pop_front();
            check("busy_len", 32'(hi), 32'(lat));
            check("b", {24'd0, bus.b_bo}, {24'd0, exp[7:0]});
            check("err", {31'd0, bus.err_o}, {31'd0, exp[8]});
            last_b   = exp[7:0];
            last_err = exp[8];
        end
    endtask

    vec_t vecs[13];

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        last_b   = 8'd0;
        last_err = 1'b0;

        vecs[0]  = '{8'd7,   8'd3,   8'd8,   1'b0};
        vecs[1]  = '{8'd10,  8'd4,   8'd216, 1'b0};
        vecs[2]  = '{8'd255, 8'd16,  8'd1,   1'b0};
        vecs[3]  = '{8'd5,   8'd2,   8'd0,   1'b1};
        vecs[4]  = '{8'd0,   8'd255, 8'd255, 1'b1};
        vecs[5]  = '{8'd2,   8'd3,   8'd255, 1'b1};
        vecs[6]  = '{8'd0,   8'd0,   8'd0,   1'b0};
        vecs[7]  = '{8'd0,   8'd1,   8'd1,   1'b0};
        vecs[8]  = '{8'd4,   8'd2,   8'd0,   1'b0};
        vecs[9]  = '{8'd1,   8'd2,   8'd27,  1'b0};
        vecs[10] = '{8'd0,   8'd2,   8'd64,  1'b0};
        vecs[11] = '{8'd20,  8'd5,   8'd125, 1'b0};
        vecs[12] = '{8'd100, 8'd9,   8'd0,   1'b1};

        // Reset
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.a_bi    = 8'd0;
        bus.y_bi    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_b", {24'd0, bus.b_bo}, 32'd0);
        check("rst_err", {31'd0, bus.err_o}, 32'd0);
        check("rst_state", {29'd0, bus.state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].a, vecs[i].y, {vecs[i].exp_err, vecs[i].exp_b});
            wait_done(1'b0);
        end

        // Random vectors, mostly near the valid d range
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra;
            logic [7:0] ry;
            int t;
            ry = 8'($urandom_range(1, 15));
            t  = int'(ry) * int'(ry) - int'($urandom_range(0, 9));
            if (t < 0 || t > 255) ra = 8'($urandom_range(0, 255));
            else ra = 8'(t);
            start_op(ra, ry, model(ra, ry));
            wait_done(1'b0);
        end

        // Handshake: start held high with changing operands during a run
        start_op(8'd7, 8'd3, {1'b0, 8'd8});
        wait_done(1'b1);
        @(posedge clk);
        exp_q.push_back({1'b0, 8'd8});
        lat_q.push_back(OK_LAT);
        #1;
        check("accept_first_idle", {31'd0, bus.busy_o}, 32'd1);
        bus.start_i = 1'b0;
        wait_done(1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("no_extra_run", {31'd0, bus.busy_o}, 32'd0);

        // Asynchronous reset during SQ cycle 4
        start_op(8'd7, 8'd3, {1'b0, 8'd8});
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("arst_b", {24'd0, bus.b_bo}, 32'd0);
        check("arst_err", {31'd0, bus.err_o}, 32'd0);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        last_b   = 8'd0;
        last_err = 1'b0;
        @(posedge clk);
        #1;
        check("arst_hold_busy", {31'd0, bus.busy_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'd7, 8'd3, {1'b0, 8'd8});
        wait_done(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fun_inv.md
# fun_inv

Inverse evaluator for the team's forward function y = sqrt(a + cbrt(b)). Given 8-bit operands a and y, it computes b = (y² − a)³ with a sequential shift-add datapath. It range-checks the result against the 8-bit b domain of the forward block. It uses the same start/busy handshake as the forward block, so a bench or controller can chain the two for round-trip checks.

## Interface
- Parameters: none; the datapath is fixed at 8-bit operands and an 8-bit result.
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset, asynchronous, active-low
- start_i  input  1  request; sampled only while busy_o = 0
- a_bi  input  8  operand a, unsigned
- y_bi  input  8  operand y, unsigned
- busy_o  output  1  high while a computation is in progress
- b_bo  output  8  result b, unsigned, registered
- err_o  output  1  result out of range, registered

## Operation
- Reset values (rst_i = 0, asynchronous): state IDLE, busy_o = 0, b_bo = 0, err_o = 0, all internal registers 0.
- Operand capture:
  - On a start_i = 1 edge in IDLE, a_bi and y_bi are latched.
  - Input changes after that edge do not affect the result.
- busy_o is combinational and equals (state != IDLE).
- States:
  - IDLE: go to SQ on start_i.
  - SQ: 8 cycles. Computes sq = y·y (16-bit) with a shift-add, one multiplier bit per cycle, LSB first.
  - CHK: 1 cycle. Compares sq against a and forms d.
  - CUBE_A: 3 cycles. Computes p = d·d (6-bit), one bit of d per cycle.
  - CUBE_B: 3 cycles. Computes c = p·d (8-bit), one bit of d per cycle.
  - DONE: 1 cycle. Loads b_bo and err_o, then returns to IDLE.
- Arithmetic rules in CHK:
  - If sq < a (underflow): err = 1, b = 0.
  - Else d = sq − a (16-bit). If d > 6, the cube exceeds 255: err = 1, b = 255.
  - Else err = 0 and b = d³, with range 0..216.
- Cube operands: when err = 1, the cube states run with d forced to 0. The saturated value, not the cube, is loaded in DONE.
- start_i while busy_o = 1 is ignored. The request is neither queued nor latched.
- b_bo and err_o hold their values until the next DONE or a reset.
- Reset mid-operation: the state returns to IDLE immediately, outputs clear to 0, and the partial result is discarded.

## Timing
- Edge numbering: the start_i sampling edge is edge 0.
- busy_o is 1 from edge 0 until the DONE→IDLE edge.
- Full path: SQ(8) + CHK(1) + CUBE_A(3) + CUBE_B(3) + DONE(1) gives busy_o high for 16 cycles. b_bo and err_o update on edge 16.
- Early-exit path (macro enabled, err = 1 in CHK): CHK goes directly to DONE. busy_o is high for 10 cycles and outputs update on edge 10.
- Outputs change on the same edge busy_o falls. A consumer may sample b_bo on the first cycle busy_o = 0.
- Back-to-back starts:
  - start_i held high through DONE is ignored.
  - The first cycle with busy_o = 0 accepts a new start.
  - The minimum start-to-start interval is therefore 17 cycles (11 on the early-exit path).

## Configuration
- FUN_INV_EARLY_EXIT_EN
  - Defined: CHK branches straight to DONE on underflow or d > 6, giving 10-cycle latency for error results.
  - Not defined: every request takes the full path with fixed 16-cycle latency. Error results are still saturated as specified.
  - b_bo and err_o values are identical in both builds; only latency differs.

## Test plan
- Nominal: y=3, a=7 → d=2, b_bo=8, err_o=0; busy_o high exactly 16 cycles.
- Boundary: y=4, a=10 → d=6, b_bo=216, err_o=0; and y=16, a=255 → d=1, b_bo=1, err_o=0.
- Underflow: y=2, a=5 → b_bo=0, err_o=1. busy_o lasts 10 cycles with FUN_INV_EARLY_EXIT_EN, 16 without.
- Overflow: y=255, a=0 → b_bo=255, err_o=1; then y=3, a=2 → d=7, b_bo=255, err_o=1.
- Handshake: pulse start_i on every cycle during a y=3, a=7 run with a_bi/y_bi toggling → exactly one result (8). The next start is accepted only on the first busy_o = 0 cycle.
- Reset:
  - Assert rst_i low during SQ cycle 4 → busy_o, b_bo and err_o are 0 immediately (asynchronous).
  - After release, a new y=3, a=7 request completes normally with b_bo=8.
